// File: rtl/click_rx_sync.sv
// click_rx_sync: clocked sink for a 2-phase bundled-data click channel; FIFO-buffered valid/ready output.
// Latency: in_req toggle before edge E1 -> captured, in_ack toggled and out_valid raised at E3 (empty FIFO).
// Backpressure: when the FIFO is full in_ack is withheld; the token stays pending until a pop frees space.
//
// Ports (click_rx_sync):
//   clk, rst_n          sole clock (rising edge), synchronous active-low reset
//   in_req, in_data     2-phase request (async to clk) and its bundled data
//   in_ack              2-phase acknowledge, straight from a flop
//   out_valid/out_ready valid/ready handshake for the head FIFO entry
//   out_data            head FIFO entry (registered storage only)
//   out_count           FIFO occupancy, 0..DEPTH

// click_rx_fifo: generic power-of-two register FIFO with occupancy count.
// Latency: a pushed entry is visible at the head the cycle after the push edge (when the FIFO was empty).
// Backpressure: none internally; the caller only pushes when not full or when popping in the same edge.
//
// Ports (click_rx_fifo):
//   clk, rst_n          clock, synchronous active-low reset (pointers/count only)
//   i_push, i_push_dat  write strobe and data
//   i_pop               advance the read pointer (caller guarantees non-empty)
//   o_head_dat          entry at the read pointer
//   o_count             occupancy, 0..DEPTH
module click_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [DATA_WIDTH-1:0]    i_push_dat,
    input  logic                     i_pop,
    output logic [DATA_WIDTH-1:0]    o_head_dat,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    // Storage carries no reset: contents are don't-care while the count is zero.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // DEPTH is a power of two, so natural pointer overflow is the modulo-DEPTH wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_count    = r_count;
endmodule

module click_rx_sync #(
    parameter int   DATA_WIDTH = 8,
    parameter int   DEPTH      = 4,
    parameter logic PHASE_INIT = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_req,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     in_ack,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   out_count
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic          r_req_s1;
    logic          r_req_s2;
    logic          r_ack_phase;
    logic          w_pending;
    logic          w_not_empty;
    logic          w_pop;
    logic          w_capture;
    logic [CW-1:0] w_count;

    // Plain two-flop synchroniser; nothing may sit between the two stages.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_req_s1 <= PHASE_INIT;
            r_req_s2 <= PHASE_INIT;
        end else begin
            r_req_s1 <= in_req;
            r_req_s2 <= r_req_s1;
        end
    end

    // Level compare of request vs. acknowledge phase: a token stays pending
    // for as many cycles as needed, so a stalled cycle can never drop it.
    assign w_pending   = r_req_s2 ^ r_ack_phase;
    assign w_not_empty = (w_count != '0);
    assign w_pop       = w_not_empty & out_ready;
    // Occupancy never exceeds DEPTH, so "not equal to DEPTH" means "has space".
    // A pop in the same edge frees the slot, allowing capture while full.
    assign w_capture   = w_pending & ((w_count != FULL_CNT) | w_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ack_phase <= PHASE_INIT;
        end else if (w_capture) begin
            r_ack_phase <= ~r_ack_phase;
        end
    end

    click_rx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_capture),
        .i_push_dat (in_data),
        .i_pop      (w_pop),
        .o_head_dat (out_data),
        .o_count    (w_count)
    );

    assign in_ack    = r_ack_phase;
    assign out_valid = w_not_empty;
    assign out_count = w_count;
endmodule
